// File: rtl/pwm_pkg.sv
// Shared definitions for the constant-on-time PWM sequencer:
// state encoding and default widths.
package pwm_pkg;

  localparam int ST_W      = 3;
  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    DT1   = 3'd1,
    HS_ON = 3'd2,
    DT2   = 3'd3,
    LS_ON = 3'd4,
    FAULT = 3'd5
  } pwm_state_e;

endpackage

// File: rtl/cot_timer.sv
// Loadable down-counter shared by all timed phases of the PWM sequencer.
// A load value of 0 or 1 gives a one-cycle phase; the counter then rests
// at 1 so 'expired' stays asserted until the next load.
module cot_timer
  import pwm_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_r;

  // Load on phase entry (zero clamped to one), then count down to one and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= (load_val == '0) ? ONE : load_val;
    end else if (cnt_r > ONE) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r <= ONE);

endmodule

// File: rtl/cot_pwm_ctrl.sv
// Constant-on-time PWM sequencer for one synchronous buck half-bridge.
// Cycle: trigger -> dead time -> high side on -> dead time -> low side on
// (minimum off-time) -> re-arm. Latches external faults until cleared.
// Optional macro COT_ZCD_EN adds a zero-cross input for diode emulation.
module cot_pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF,
  parameter int ST_W  = pwm_pkg::ST_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             set,
  input  logic [CNT_W-1:0] ton_cycles,
  input  logic [DT_W-1:0]  dt_cycles,
  input  logic [CNT_W-1:0] toff_min_cycles,
  input  logic             fault,
  input  logic             fault_clr,
`ifdef COT_ZCD_EN
  input  logic             zcd,
`endif
  output logic             hs_gate,
  output logic             ls_gate,
  output logic             cycle_done,
  output logic             fault_latched,
  output logic [ST_W-1:0]  state
);

  pwm_state_e       state_r;
  pwm_state_e       state_nxt_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             tmr_expired_s;
  logic             zcd_s;
  logic             hs_gate_r;
  logic             ls_gate_r;
  logic             cycle_done_r;
  logic             fault_latched_r;

`ifdef COT_ZCD_EN
  assign zcd_s = zcd;
`else
  assign zcd_s = 1'b0;
`endif

  cot_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .expired  (tmr_expired_s)
  );

  // Next-state logic; a sampled fault overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (fault) begin
      state_nxt_s = FAULT;
    end else begin
      case (state_r)
        IDLE: begin
          if (en && set) state_nxt_s = DT1;
          else           state_nxt_s = IDLE;
        end
        DT1: begin
          if (tmr_expired_s) state_nxt_s = HS_ON;
          else               state_nxt_s = DT1;
        end
        HS_ON: begin
          if (tmr_expired_s) state_nxt_s = DT2;
          else               state_nxt_s = HS_ON;
        end
        DT2: begin
          if (!tmr_expired_s) state_nxt_s = DT2;
          else if (en)        state_nxt_s = LS_ON;
          else                state_nxt_s = IDLE;
        end
        LS_ON: begin
          // set is not honoured until the minimum off-time has elapsed
          if (!tmr_expired_s) state_nxt_s = LS_ON;
          else if (!en)       state_nxt_s = IDLE;
          else if (set)       state_nxt_s = DT1;
          else if (zcd_s)     state_nxt_s = IDLE;
          else                state_nxt_s = LS_ON;
        end
        FAULT: begin
          if (fault_clr) state_nxt_s = IDLE;
          else           state_nxt_s = FAULT;
        end
        // Unreachable encodings shut the bridge down.
        default: state_nxt_s = FAULT;
      endcase
    end
  end

  // Reload the shared timer on every state change with the new phase length.
  always_comb begin
    load_s     = (state_nxt_s != state_r);
    load_val_s = '0;
    case (state_nxt_s)
      DT1, DT2: load_val_s = CNT_W'(dt_cycles);
      HS_ON:    load_val_s = ton_cycles;
      LS_ON:    load_val_s = toff_min_cycles;
      default:  load_val_s = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Output flops decoded from the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_gate_r       <= 1'b0;
      ls_gate_r       <= 1'b0;
      cycle_done_r    <= 1'b0;
      fault_latched_r <= 1'b0;
    end else begin
      hs_gate_r       <= (state_nxt_s == HS_ON);
      ls_gate_r       <= (state_nxt_s == LS_ON);
      cycle_done_r    <= (state_r == HS_ON) && (state_nxt_s == DT2);
      fault_latched_r <= (state_nxt_s == FAULT);
    end
  end

  assign hs_gate       = hs_gate_r;
  assign ls_gate       = ls_gate_r;
  assign cycle_done    = cycle_done_r;
  assign fault_latched = fault_latched_r;
  assign state         = ST_W'(state_r);

endmodule

// File: doc/cot_pwm_ctrl.md
Name: cot_pwm_ctrl

Overview:
Constant-on-time (COT) PWM sequencer for one synchronous buck half-bridge. It paces each switching cycle around the on-time timer: comparator trigger → dead time → high-side on for ton → dead time → low-side on with minimum off-time → re-arm. It drives the gate-enable signals consumed by the gate-driver output stage. It also owns fault shutdown and the run enable.

Parameters:
CNT_W, 16, width of ton_cycles / toff_min_cycles and the shared down-counter
DT_W, 8, width of dt_cycles
ST_W, 3, width of the state output

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable (level)
set  in  1  comparator trigger (level, sampled on clk)
ton_cycles  in  CNT_W  high-side on-time in clk cycles
dt_cycles  in  DT_W  dead time in clk cycles
toff_min_cycles  in  CNT_W  minimum low-side on-time in clk cycles
fault  in  1  external fault (level, synchronous sample)
fault_clr  in  1  fault latch clear
hs_gate  out  1  high-side gate enable
ls_gate  out  1  low-side gate enable
cycle_done  out  1  one-cycle pulse at end of each HS_ON
fault_latched  out  1  high while in FAULT
state  out  ST_W  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, hs_gate=0, ls_gate=0, cycle_done=0, fault_latched=0, counter=0. Reset asserted mid-cycle forces both gates low immediately (async).
- States: IDLE=0, DT1=1, HS_ON=2, DT2=3, LS_ON=4, FAULT=5.
- Gate decode: hs_gate=(state==HS_ON) and ls_gate=(state==LS_ON), both decoded from the state register (glitch-free). hs_gate&ls_gate is never 1.
- Timed states: DT1, HS_ON and DT2 last exactly N cycles. N is sampled into the down-counter on the entry edge. A programmed value of 0 is treated as 1. Input changes mid-state have no effect until the next entry.
- IDLE: if en&set, go to DT1. Otherwise stay.
- DT1: on expiry, go to HS_ON.
- HS_ON: on expiry, go to DT2 and pulse cycle_done for 1 cycle (the first DT2 cycle). en falling during HS_ON does not truncate the on-time.
- DT2: on expiry, go to LS_ON if en, else IDLE.
- LS_ON: counts toff_min_cycles (0 treated as 1). set is ignored until the minimum off-time has elapsed. After that, in priority order:
  - !en: go to IDLE.
  - set: go to DT1.
  - otherwise stay, with ls_gate held.
- set is level-sampled, not edge-detected, and not queued. A set held high re-triggers at the first legal cycle.
- Fault: fault=1 sampled in any state moves to FAULT on the next edge and has priority over every other transition. In FAULT both gates are 0 and fault_latched=1. Exit to IDLE only when fault_clr=1 and fault=0 in the same cycle.
- Counter is CNT_W wide. dt_cycles is zero-extended.

Optional Feature:
COT_ZCD_EN:
- Defined: adds input zcd (1 bit, inductor zero-cross detect) for diode emulation. In LS_ON after the minimum off-time, zcd=1 with set=0 moves to IDLE (both gates off). The skip state lasts until the next en&set. set has priority over zcd in the same cycle.
- Undefined: no zcd port. LS_ON holds until set or !en.

Decomposition:
- Package pwm_pkg: state localparams (IDLE…FAULT), ST_W, default CNT_W/DT_W.
- Sub-module cot_timer: loadable down-counter with load, load_val, and an expired flag (value≤1 on load means 1-cycle expiry). One instance is shared across DT1, HS_ON, DT2 and LS_ON.

Test Plan:
- Nominal timing: ton=10, dt=3, toff_min=5, en=1, set held high from cycle 0.
  - DT1 in cycles 1–3; hs_gate high in cycles 4–13; cycle_done at cycle 14; DT2 in cycles 14–16.
  - ls_gate high in cycles 17–21; DT1 again at cycle 22. Period = 21 cycles.
- Minimum off-time: set pulsed high only at cycle 18 (inside min off) → ignored; ls_gate stays high until set rises at cycle 30 → DT1 at cycle 31.
- Fault mid-cycle: fault=1 at cycle 8 (HS_ON) → cycle 9 state=FAULT, hs_gate=0, fault_latched=1. fault_clr with fault=1 → stays in FAULT. fault_clr with fault=0 → IDLE.
- Zero config and enable drop: ton=0, dt=0 → HS_ON and DT each last 1 cycle. en dropped during HS_ON → full ton, then DT2, then IDLE with both gates 0.
- Async reset: rst asserted between edges during HS_ON → hs_gate=0 before the next clk edge; all outputs at reset values.
- COT_ZCD_EN: zcd=1 at cycle 25 (min off elapsed, set=0) → IDLE at cycle 26, ls_gate=0. zcd=1 and set=1 in the same cycle → DT1.
